// File: rtl/loop_addr_gen_pkg.sv
// Shared types and defaults for the loop_addr_gen nested-loop address generator.
package loop_addr_gen_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned AW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lag_state_e;

  typedef struct packed {
    logic [AW_DEF-1:0] base;
    logic [AW_DEF-1:0] stride;
    logic [DW_DEF-1:0] max_col;
    logic [DW_DEF-1:0] max_row;
  } lag_cfg_t;

endpackage

// File: rtl/loop_addr_gen_counter_max.sv
// CounterMax stage: counts 0..max on en, wraps to 0 and raises co on the wrapping enable.
module loop_addr_gen_counter_max #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] max,
  output logic [DW-1:0] cnt,
  output logic          co
);

  assign co = en & (cnt == max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= co ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/loop_addr_gen.sv
// Row x col nested-loop address generator with valid/ready output stream.
// Optional macro LOOP_ADDR_GEN_LAST_EN adds out_row_last / out_last markers.
module loop_addr_gen
  import loop_addr_gen_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          clear,
  input  logic [AW-1:0] cfg_base,
  input  logic [AW-1:0] cfg_stride,
  input  logic [DW-1:0] cfg_max_col,
  input  logic [DW-1:0] cfg_max_row,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic          busy,
`ifdef LOOP_ADDR_GEN_LAST_EN
  output logic          out_row_last,
  output logic          out_last,
`endif
  output logic          done
);

  lag_state_e    state_q, state_d;
  logic [AW-1:0] stride_q;
  logic [DW-1:0] max_col_q, max_row_q;
  logic [AW-1:0] row_base_q;
  logic [DW-1:0] col_cnt, row_cnt;
  logic          col_co, row_co;
  logic          beat, last_beat, cnt_clr, accept;

  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign beat      = out_valid & out_ready;
  // row counter only sees the col carry, so row_co already implies col_co
  assign last_beat = col_co & row_co;
  assign cnt_clr   = clear | (state_q != RUN);
  assign accept    = (state_q == IDLE) & start & ~clear;

  loop_addr_gen_counter_max #(.DW(DW)) u_col (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (beat),
    .max   (max_col_q),
    .cnt   (col_cnt),
    .co    (col_co)
  );

  loop_addr_gen_counter_max #(.DW(DW)) u_row (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (col_co),
    .max   (max_row_q),
    .cnt   (row_cnt),
    .co    (row_co)
  );

`ifdef LOOP_ADDR_GEN_LAST_EN
  assign out_row_last = out_valid & (col_cnt == max_col_q);
  assign out_last     = out_valid & (col_cnt == max_col_q) & (row_cnt == max_row_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // Incremental addressing: row_base tracks the first address of the current row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q   <= '0;
      max_col_q  <= '0;
      max_row_q  <= '0;
      row_base_q <= '0;
      out_addr   <= '0;
    end else if (accept) begin
      stride_q   <= cfg_stride;
      max_col_q  <= cfg_max_col;
      max_row_q  <= cfg_max_row;
      row_base_q <= cfg_base;
      out_addr   <= cfg_base;
    end else if (beat && !clear && !last_beat) begin
      if (col_co) begin
        row_base_q <= row_base_q + stride_q;
        out_addr   <= row_base_q + stride_q;
      end else begin
        out_addr   <= out_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_loop_addr_gen.sv
// Directed self-checking bench for loop_addr_gen (row x col address sweep).
module tb_loop_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, clear, out_ready;
  logic [15:0] cfg_base, cfg_stride;
  logic [7:0]  cfg_max_col, cfg_max_row;
  logic        out_valid, busy, done;
  logic [15:0] out_addr;
`ifdef LOOP_ADDR_GEN_LAST_EN
  logic        out_row_last, out_last;
`endif

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_a [8];

  always #5 clk = ~clk;

  loop_addr_gen #(.DW(8), .AW(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .clear       (clear),
    .cfg_base    (cfg_base),
    .cfg_stride  (cfg_stride),
    .cfg_max_col (cfg_max_col),
    .cfg_max_row (cfg_max_row),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .busy        (busy),
`ifdef LOOP_ADDR_GEN_LAST_EN
    .out_row_last(out_row_last),
    .out_last    (out_last),
`endif
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [15:0] b, input logic [15:0] s,
                             input logic [7:0] mc, input logic [7:0] mr);
    cfg_base = b; cfg_stride = s; cfg_max_col = mc; cfg_max_row = mr;
    start = 1'b1; clear = 1'b0; out_ready = 1'b0;
    step();
    start = 1'b0;
    // scramble cfg after the start edge; it must not be picked up
    cfg_base = 16'hDEAD; cfg_stride = 16'h0BAD; cfg_max_col = 8'd9; cfg_max_row = 8'd9;
    check("start busy", busy, 1);
    check("start addr", out_addr, b);
  endtask

  // mode 0: ready=1; mode 1: ready toggles, held low 5 cycles while beat 3 is offered
  task automatic collect(input int n, input int cols, input int mode, input string tag);
    int idx = 0;
    int c = 0;
    int hold = 0;
    bit stall = 0;
    logic [15:0] held = '0;
    while (idx < n && c < 200) begin
      if (mode == 0) out_ready = 1'b1;
      else if (idx == 2 && hold < 5) begin out_ready = 1'b0; hold++; end
      else out_ready = (c % 2 == 0);
      if (stall) check({tag, " stall hold"}, out_addr, held);
      stall = 0;
      if (out_valid && out_ready) begin
        check({tag, " addr"}, out_addr, exp_a[idx]);
`ifdef LOOP_ADDR_GEN_LAST_EN
        check({tag, " row_last"}, out_row_last, ((idx % cols) == cols - 1));
        check({tag, " last"}, out_last, (idx == n - 1));
`endif
        idx++;
      end else if (out_valid) begin
        stall = 1;
        held = out_addr;
      end else begin
        check({tag, " valid gap"}, out_valid, 1);
      end
      step();
      c++;
    end
    out_ready = 1'b0;
    check({tag, " beats"}, idx, n);
    check({tag, " done"}, done, 1);
    check({tag, " done busy"}, busy, 0);
    check({tag, " done valid"}, out_valid, 0);
    step();
    check({tag, " done pulse"}, done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 0; clear = 0; out_ready = 0;
    cfg_base = '0; cfg_stride = '0; cfg_max_col = '0; cfg_max_row = '0;
    #12;
    check("rst valid", out_valid, 0);
    check("rst addr", out_addr, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    rst_n = 1'b1;
    step();

    // basic
    exp_a[0] = 16'h100; exp_a[1] = 16'h101; exp_a[2] = 16'h102;
    exp_a[3] = 16'h110; exp_a[4] = 16'h111; exp_a[5] = 16'h112;
    start_frame(16'h100, 16'h10, 8'd2, 8'd1);
    collect(6, 3, 0, "basic");

    // backpressure
    start_frame(16'h100, 16'h10, 8'd2, 8'd1);
    collect(6, 3, 1, "bp");

    // degenerate
    exp_a[0] = 16'h7;
    start_frame(16'h7, 16'h4, 8'd0, 8'd0);
    collect(1, 1, 0, "one");
    exp_a[0] = 16'h7; exp_a[1] = 16'hB; exp_a[2] = 16'hF; exp_a[3] = 16'h13;
    start_frame(16'h7, 16'h4, 8'd0, 8'd3);
    collect(4, 1, 0, "col0");

    // address wrap
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
    start_frame(16'hFFFE, 16'h1, 8'd3, 8'd0);
    collect(4, 4, 0, "wrap");

    // start during RUN ignored
    exp_a[0] = 16'h100; exp_a[1] = 16'h101; exp_a[2] = 16'h102;
    exp_a[3] = 16'h110; exp_a[4] = 16'h111; exp_a[5] = 16'h112;
    start_frame(16'h100, 16'h10, 8'd2, 8'd1);
    start = 1'b1; cfg_base = 16'h500;
    step(); step();
    check("run start addr", out_addr, 16'h100);
    start = 1'b0;
    collect(6, 3, 0, "restart ign");

    // clear after beat 2
    start_frame(16'h100, 16'h10, 8'd2, 8'd1);
    out_ready = 1'b1;
    step(); step();
    check("pre clear addr", out_addr, 16'h102);
    clear = 1'b1;
    step();
    clear = 1'b0; out_ready = 1'b0;
    check("clear valid", out_valid, 0);
    check("clear busy", busy, 0);
    check("clear done", done, 0);
    step();
    check("clear no done", done, 0);
    start_frame(16'h100, 16'h10, 8'd2, 8'd1);
    collect(6, 3, 0, "after clear");

    // clear beats start in IDLE
    clear = 1'b1; start = 1'b1;
    step();
    clear = 1'b0; start = 1'b0;
    check("clr+start busy", busy, 0);
    check("clr+start valid", out_valid, 0);

    // asynchronous reset mid-frame
    start_frame(16'h100, 16'h10, 8'd2, 8'd1);
    out_ready = 1'b1;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("arst valid", out_valid, 0);
    check("arst addr", out_addr, 0);
    check("arst busy", busy, 0);
    check("arst done", done, 0);
    out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    exp_a[0] = 16'h42;
    start_frame(16'h42, 16'h1, 8'd0, 8'd0);
    collect(1, 1, 0, "post rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
